print_uart_tx: RTL and testbench

//  Consumes the core's print port (PRINT_VAL/PRINT_EN from the memory stage) and sends each
//  32-bit word off-chip on a UART 8N1 line. Words are queued in a FIFO, so back-to-back store

---
 rtl/print_uart_tx.sv | 196 +++++++++++++++++++
 tb/tb_print_uart_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/print_uart_tx.sv
// print_uart_tx: drains the core's print port through a word FIFO and sends each
// 32-bit word on a UART 8N1 line (TX idles high).
// Build option PRINT_HEX_ASCII_EN: when defined, every word is sent as eight
// uppercase ASCII hex digits (most-significant nibble first) followed by LF.
// When undefined, every word is sent as four raw bytes, least-significant first.
module print_uart_tx #(
    parameter int BAUD_DIV = 868,
    parameter int DEPTH    = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [31:0]              PRINT_VAL,
    input  logic                     PRINT_EN,
    input  logic                     CLR_OVF,
    output logic                     TX,
    output logic                     BUSY,
    output logic [$clog2(DEPTH):0]   FIFO_COUNT,
    output logic                     OVERFLOW
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int PW = $clog2(DEPTH);

`ifdef PRINT_HEX_ASCII_EN
    localparam int NFRAMES = 9;
    localparam int BIW     = 4;
`else
    localparam int NFRAMES = 4;
    localparam int BIW     = 2;
`endif

    localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [BIW-1:0] LAST_BYTE = BIW'(NFRAMES - 1);
    localparam logic [PW:0]    FULL      = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [BIW-1:0]  byte_idx;
    logic [31:0]     w_reg;
    logic [31:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count_nxt;
    logic            push_ok;
    logic            pop;
    logic            bit_done;
    logic            last_byte;
    logic [7:0]      cur_byte;
    logic            tx_nxt;
    logic            busy_nxt;

`ifdef PRINT_HEX_ASCII_EN
    // Uppercase ASCII for one hex nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    // Frame idx of a word: digits 0..7 walk from the top nibble down, frame 8 is LF.
    function automatic logic [7:0] frame_byte(input logic [31:0] w, input logic [BIW-1:0] idx);
        logic [3:0] nib;
        if (idx == 4'd8)
            return 8'h0A;
        nib = w[(5'd28 - {idx[2:0], 2'b00}) +: 4];
        return hex_ascii(nib);
    endfunction
`else
    // Frame idx of a word: raw byte idx, least-significant byte first.
    function automatic logic [7:0] frame_byte(input logic [31:0] w, input logic [BIW-1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction
`endif

    assign bit_done  = (baud_cnt == BAUD_LAST);
    assign last_byte = (byte_idx == LAST_BYTE);
    assign pop       = (state == S_IDLE) && (FIFO_COUNT != '0);
    // A full FIFO still accepts a push on the edge that frees a slot.
    assign push_ok   = PRINT_EN && ((FIFO_COUNT != FULL) || pop);
    assign cur_byte  = frame_byte(w_reg, byte_idx);

    // FIFO occupancy after this edge.
    always_comb begin
        count_nxt = FIFO_COUNT;
        case ({push_ok, pop})
            2'b10:   count_nxt = FIFO_COUNT + 1'b1;
            2'b01:   count_nxt = FIFO_COUNT - 1'b1;
            default: count_nxt = FIFO_COUNT;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state: frames of one word run back to back, IDLE only between words.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pop) state_nxt = S_START;
            S_START: if (bit_done) state_nxt = S_DATA;
            S_DATA:  if (bit_done && (bit_idx == 3'd7)) state_nxt = S_STOP;
            S_STOP:  if (bit_done) state_nxt = last_byte ? S_IDLE : S_START;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: line level for the current bit and the busy flag to register.
    always_comb begin
        tx_nxt = 1'b1;
        case (state)
            S_START: tx_nxt = 1'b0;
            S_DATA:  tx_nxt = cur_byte[bit_idx];
            default: tx_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != S_IDLE) || (FIFO_COUNT != '0);
    end

    // Registered line and busy outputs; reset forces the line idle at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            TX   <= 1'b1;
            BUSY <= 1'b0;
        end else begin
            TX   <= tx_nxt;
            BUSY <= busy_nxt;
        end
    end

    // Baud, bit and byte counters; the baud counter wraps at each bit boundary.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
        end else if (state == S_IDLE) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (pop)
                byte_idx <= '0;
        end else begin
            baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
            if (bit_done && (state == S_DATA))
                bit_idx <= bit_idx + 1'b1;
            if (bit_done && (state == S_STOP))
                byte_idx <= byte_idx + 1'b1;
        end
    end

    // Shift holding register loaded from the FIFO head on pop.
    always_ff @(posedge CLK) begin
        if (pop)
            w_reg <= mem[rd_ptr];
    end

    // FIFO storage; on a full push+pop the head is read before being overwritten.
    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wr_ptr] <= PRINT_VAL;
    end

    // FIFO pointers, occupancy and the sticky overflow flag (set beats clear).
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_COUNT <= '0;
            OVERFLOW   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            FIFO_COUNT <= count_nxt;
            if (PRINT_EN && !push_ok)
                OVERFLOW <= 1'b1;
            else if (CLR_OVF)
                OVERFLOW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_print_uart_tx.sv
// Testbench for print_uart_tx with BAUD_DIV=4, DEPTH=4. Expected UART bytes are
// queued when words are pushed and checked by a mid-bit sampling line monitor.
module tb_print_uart_tx;

    localparam int BD    = 4;
    localparam int DEP   = 4;
`ifdef PRINT_HEX_ASCII_EN
    localparam int NFR   = 9;
`else
    localparam int NFR   = 4;
`endif
    localparam int WCYC  = NFR * 10 * BD;

    logic        CLK;
    logic        RESET;
    logic [31:0] PRINT_VAL;
    logic        PRINT_EN;
    logic        CLR_OVF;
    logic        TX;
    logic        BUSY;
    logic [2:0]  FIFO_COUNT;
    logic        OVERFLOW;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rst_epoch = 0;
    logic [7:0]  exp_q [$];

    print_uart_tx #(.BAUD_DIV(BD), .DEPTH(DEP)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .PRINT_VAL  (PRINT_VAL),
        .PRINT_EN   (PRINT_EN),
        .CLR_OVF    (CLR_OVF),
        .TX         (TX),
        .BUSY       (BUSY),
        .FIFO_COUNT (FIFO_COUNT),
        .OVERFLOW   (OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected frame f of word v.
    function automatic logic [7:0] exp_frame(input logic [31:0] v, input int f);
        logic [3:0] nib;
`ifdef PRINT_HEX_ASCII_EN
        if (f == 8) return 8'h0A;
        nib = 4'((v >> (28 - 4 * f)) & 32'hF);
        return (nib < 10) ? (8'd48 + 8'(nib)) : (8'd65 + 8'(nib) - 8'd10);
`else
        nib = 4'h0;
        return 8'((v >> (8 * f)) & 32'hFF) | {4'h0, nib};
`endif
    endfunction

    task automatic push_expected(input logic [31:0] v);
        for (int f = 0; f < NFR; f++)
            exp_q.push_back(exp_frame(v, f));
    endtask

    // Line monitor: start detected at a falling-edge sample, then every bit sampled mid-bit.
    always begin : uart_mon
        logic [7:0]  b;
        logic [7:0]  e;
        int          ep;
        @(negedge CLK);
        if (!RESET && TX === 1'b0) begin
            ep = rst_epoch;
            @(negedge CLK);
            if (ep == rst_epoch) check_val("rx_start", TX, 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (BD) @(negedge CLK);
                b[i] = TX;
            end
            repeat (BD) @(negedge CLK);
            if (ep == rst_epoch) begin
                check_val("rx_stop", TX, 1'b1);
                if (exp_q.size() == 0) begin
                    check_val("rx_unexpected", {24'h0, b}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_val("rx_byte", {24'h0, b}, {24'h0, e});
                end
            end
        end
    end

    // One word from idle: latency to the start bit, busy duration, full reception.
    task automatic send_word(input logic [31:0] v);
        int busy_cyc;
        busy_cyc = 0;
        @(negedge CLK);
        PRINT_VAL = v;
        PRINT_EN  = 1'b1;
        push_expected(v);
        for (int k = 0; k < 4 * WCYC; k++) begin
            @(negedge CLK);
            PRINT_EN = 1'b0;
            if (k == 0 || k == 1) check_val("lat_tx_high", TX, 1'b1);
            if (k == 2)           check_val("lat_tx_low", TX, 1'b0);
            if (BUSY) busy_cyc++;
            else if (busy_cyc > 0) break;
        end
        check_val("busy_cycles", busy_cyc, WCYC);
        repeat (8) @(negedge CLK);
        check_val("word_drain", exp_q.size(), 0);
    endtask

    initial begin : timeout
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int maxc;
        RESET     = 1'b0;
        PRINT_EN  = 1'b0;
        PRINT_VAL = 32'h0;
        CLR_OVF   = 1'b0;
        #1;
        // Reset held with a push strobe active
        RESET     = 1'b1;
        PRINT_EN  = 1'b1;
        PRINT_VAL = 32'hDEADBEEF;
        repeat (4) begin
            @(negedge CLK);
            check_val("rst_tx", TX, 1'b1);
            check_val("rst_busy", BUSY, 1'b0);
            check_val("rst_count", FIFO_COUNT, 3'd0);
            check_val("rst_ovf", OVERFLOW, 1'b0);
        end
        RESET    = 1'b0;
        PRINT_EN = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("post_rst_tx", TX, 1'b1);

        // Single word
        send_word(32'h12345678);

        // Six consecutive pushes while idle: word 6 dropped
        maxc = 0;
        @(negedge CLK);
        for (int i = 0; i < 6; i++) begin
            PRINT_VAL = 32'(i + 1);
            PRINT_EN  = 1'b1;
            if (i < 5) push_expected(32'(i + 1));
            @(negedge CLK);
            if (int'(FIFO_COUNT) > maxc) maxc = int'(FIFO_COUNT);
        end
        PRINT_EN = 1'b0;
        check_val("burst_count", FIFO_COUNT, 3'd4);
        check_val("burst_ovf", OVERFLOW, 1'b1);
        check_val("burst_peak", maxc, 4);

        // Clear the sticky flag
        CLR_OVF = 1'b1;
        @(negedge CLK);
        CLR_OVF = 1'b0;
        check_val("clr_ovf", OVERFLOW, 1'b0);

        // Push on the edge where the full FIFO pops
        repeat (WCYC - 5) @(negedge CLK);
        check_val("full_pre", FIFO_COUNT, 3'd4);
        PRINT_VAL = 32'h7;
        PRINT_EN  = 1'b1;
        push_expected(32'h7);
        @(negedge CLK);
        PRINT_EN = 1'b0;
        check_val("poppush_count", FIFO_COUNT, 3'd4);
        check_val("poppush_ovf", OVERFLOW, 1'b0);

        // Clear coinciding with an overflowing push: set wins
        PRINT_VAL = 32'h8;
        PRINT_EN  = 1'b1;
        CLR_OVF   = 1'b1;
        @(negedge CLK);
        PRINT_EN = 1'b0;
        CLR_OVF  = 1'b0;
        check_val("clr_vs_set_ovf", OVERFLOW, 1'b1);
        check_val("clr_vs_set_count", FIFO_COUNT, 3'd4);

        // Drain the queue
        for (int k = 0; k < 8 * WCYC; k++) begin
            @(negedge CLK);
            if (!BUSY) break;
        end
        check_val("drain_busy", BUSY, 1'b0);
        repeat (8) @(negedge CLK);
        check_val("drain_queue", exp_q.size(), 0);
        check_val("drain_count", FIFO_COUNT, 3'd0);

        // Word used for the ASCII example
        send_word(32'h00C0FFEE);

        // Reset in the middle of the second frame
        @(negedge CLK);
        PRINT_VAL = 32'hAABBCCDD;
        PRINT_EN  = 1'b1;
        push_expected(32'hAABBCCDD);
        @(negedge CLK);
        PRINT_EN = 1'b0;
        repeat (50) @(negedge CLK);
        #2;
        RESET = 1'b1;
        rst_epoch++;
        exp_q.delete();
        #1;
        check_val("midrst_tx", TX, 1'b1);
        check_val("midrst_busy", BUSY, 1'b0);
        check_val("midrst_count", FIFO_COUNT, 3'd0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (60) @(negedge CLK);
        check_val("midrst_idle_tx", TX, 1'b1);
        check_val("midrst_ovf", OVERFLOW, 1'b0);
        send_word(32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
